// File: rtl/mc_pkg.sv
// Shared command encoding for the transfer-path memory controller.
// The decode function is reused by the transfer FSM.
package mc_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE,
        CMD_CLR,
        CMD_WR,
        CMD_WR_REJ,
        CMD_RD,
        CMD_ERR
    } cmd_e;

    function automatic cmd_e decode(
        input logic clr,
        input logic we,
        input logic re,
        input logic full,
        input logic wrapEn
    );
        cmd_e c;
        c = CMD_IDLE;
        // Terms are mutually exclusive, so the priority order is explicit.
        unique case (1'b1)
            clr:                                  c = CMD_CLR;
            !clr && we && re:                     c = CMD_ERR;
            !clr && we && !re && (!full || wrapEn): c = CMD_WR;
            !clr && we && !re && full && !wrapEn: c = CMD_WR_REJ;
            !clr && !we && re:                    c = CMD_RD;
            default:                              c = CMD_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_xfer_param_if.sv
// Command/status bundle between the transfer FSM and a buffer memory.
interface mc_xfer_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              WE;
    logic              RE;
    logic              Clr;
    logic [DATA_W-1:0] DataIn;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] DataOut;
    logic              DataOutValid;
    logic              Full;
    logic              Wrap;
    logic              Err;

    modport master (
        output WE, RE, Clr, DataIn,
        input  Addr, DataOut, DataOutValid, Full, Wrap, Err
    );

    modport slave (
        input  WE, RE, Clr, DataIn,
        output Addr, DataOut, DataOutValid, Full, Wrap, Err
    );
endinterface

// File: rtl/mc_addr_ctr.sv
// Auto-advancing address pointer with clear and terminal-count flag.
module mc_addr_ctr #(
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              Clr,
    input  logic              Adv,
    output logic [ADDR_W-1:0] Addr,
    output logic              Wrap,
    output logic              Tc
);
    // DEPTH is a power of two, so DEPTH-1 is all ones.
    assign Tc = (Addr == '1);

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            Addr <= '0;
            Wrap <= 1'b0;
        end else begin
            Wrap <= 1'b0;
            if (Clr) begin
                Addr <= '0;
            end else if (Adv) begin
                Addr <= Addr + 1'b1;
                Wrap <= Tc;
            end
        end
    end
endmodule

// File: rtl/mc_xfer_param.sv
// Parametrised DEPTH x DATA_W buffer memory with auto-advancing address.
module mc_xfer_param
    import mc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int WRAP_EN = 0
) (
    input logic clock,
    input logic Reset,
    mc_xfer_param_if.slave bus
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic              tc;
    logic              full;
    logic [DATA_W-1:0] dataOut;
    logic              dataOutValid;
    logic              err;
    cmd_e              cmd;

    assign cmd = decode(bus.Clr, bus.WE, bus.RE, full, WRAP_EN != 0);

    mc_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
        .clock (clock),
        .Reset (Reset),
        .Clr   (cmd == CMD_CLR),
        .Adv   (cmd == CMD_WR || cmd == CMD_RD),
        .Addr  (addr),
        .Wrap  (bus.Wrap),
        .Tc    (tc)
    );

    // Memory shares the reset domain so no write can land while Reset is high.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            dataOut      <= '0;
            dataOutValid <= 1'b0;
            full         <= 1'b0;
            err          <= 1'b0;
        end else begin
            dataOutValid <= (cmd == CMD_RD);
            err          <= (cmd == CMD_ERR) || (cmd == CMD_WR_REJ);
            if (cmd == CMD_WR) mem[addr] <= bus.DataIn;
            if (cmd == CMD_RD) dataOut <= mem[addr];
            if (cmd == CMD_CLR) full <= 1'b0;
            else if (cmd == CMD_WR && tc) full <= 1'b1;
        end
    end

    assign bus.Addr         = addr;
    assign bus.DataOut      = dataOut;
    assign bus.DataOutValid = dataOutValid;
    assign bus.Full         = full;
    assign bus.Err          = err;
endmodule

// File: tb/tb_mc_xfer_param.sv
// Directed bench: u0 rejects writes when full, u1 overwrites from address 0.
module tb_mc_xfer_param;
    logic clock = 1'b0;
    logic Reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] fillD [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] altD  [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

    mc_xfer_param_if #(.DATA_W(8), .ADDR_W(2)) b0 ();
    mc_xfer_param_if #(.DATA_W(8), .ADDR_W(2)) b1 ();

    mc_xfer_param #(.DATA_W(8), .DEPTH(4), .WRAP_EN(0)) u0 (
        .clock(clock), .Reset(Reset), .bus(b0)
    );
    mc_xfer_param #(.DATA_W(8), .DEPTH(4), .WRAP_EN(1)) u1 (
        .clock(clock), .Reset(Reset), .bus(b1)
    );

    always #5 clock = ~clock;

    task automatic setIn(input logic we, re, clr, input logic [7:0] din);
        b0.WE = we; b0.RE = re; b0.Clr = clr; b0.DataIn = din;
        b1.WE = we; b1.RE = re; b1.Clr = clr; b1.DataIn = din;
    endtask

    task automatic drive(input logic we, re, clr, input logic [7:0] din);
        @(negedge clock);
        setIn(we, re, clr, din);
        @(posedge clock);
        #1;
        setIn(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({b0.Addr, b0.DataOut, b0.DataOutValid, b0.Full, b0.Wrap, b0.Err} !== 14'h0) begin
            errors++;
            $display("FAIL reset_u0 got addr=%0d do=%h v=%b f=%b w=%b e=%b exp all 0",
                     b0.Addr, b0.DataOut, b0.DataOutValid, b0.Full, b0.Wrap, b0.Err);
        end
        checks++;
        if ({b1.Addr, b1.DataOut, b1.DataOutValid, b1.Full, b1.Wrap, b1.Err} !== 14'h0) begin
            errors++;
            $display("FAIL reset_u1 got addr=%0d do=%h f=%b exp all 0",
                     b1.Addr, b1.DataOut, b1.Full);
        end
        @(negedge clock);
        Reset = 1'b0;
    endtask

    task automatic test_fill();
        logic [4:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, fillD[i]);
            exp = {2'(i + 1), i == 3, i == 3, 1'b0};
            checks++;
            if ({b0.Addr, b0.Wrap, b0.Full, b0.Err} !== exp) begin
                errors++;
                $display("FAIL fill[%0d] addr/wrap/full/err got %b exp %b",
                         i, {b0.Addr, b0.Wrap, b0.Full, b0.Err}, exp);
            end
        end
    endtask

    task automatic test_read();
        logic [4:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            exp = {2'(i + 1), i == 3, 1'b1, 1'b0};
            checks++;
            if (b0.DataOut !== fillD[i] || b0.DataOutValid !== 1'b1) begin
                errors++;
                $display("FAIL read[%0d] data got %h v=%b exp %h v=1",
                         i, b0.DataOut, b0.DataOutValid, fillD[i]);
            end
            checks++;
            if ({b0.Addr, b0.Wrap, b0.Full, b0.Err} !== exp) begin
                errors++;
                $display("FAIL read_flags[%0d] got %b exp %b",
                         i, {b0.Addr, b0.Wrap, b0.Full, b0.Err}, exp);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({b0.DataOutValid, b0.Wrap, b0.DataOut} !== {2'b00, 8'h44}) begin
            errors++;
            $display("FAIL idle_after_read got v=%b w=%b do=%h exp v=0 w=0 do=44",
                     b0.DataOutValid, b0.Wrap, b0.DataOut);
        end
    endtask

    task automatic test_reject();
        drive(1'b1, 1'b0, 1'b0, 8'h55);
        checks++;
        if ({b0.Addr, b0.Full, b0.Err} !== 4'b0011) begin
            errors++;
            $display("FAIL reject_u0 addr/full/err got %b exp 0011",
                     {b0.Addr, b0.Full, b0.Err});
        end
        checks++;
        if ({b1.Addr, b1.Full, b1.Err, b1.Wrap} !== 5'b01100) begin
            errors++;
            $display("FAIL wrapwr_u1 addr/full/err/wrap got %b exp 01100",
                     {b1.Addr, b1.Full, b1.Err, b1.Wrap});
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (b0.DataOut !== 8'h11 || b0.Err !== 1'b0 || b0.Addr !== 2'd1) begin
            errors++;
            $display("FAIL reject_readback got do=%h e=%b a=%0d exp do=11 e=0 a=1",
                     b0.DataOut, b0.Err, b0.Addr);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if ({b1.Addr, b1.Full, b1.Wrap, b1.Err, b1.DataOutValid} !== 6'h0) begin
            errors++;
            $display("FAIL clr_u1 got a=%0d f=%b w=%b e=%b v=%b exp all 0",
                     b1.Addr, b1.Full, b1.Wrap, b1.Err, b1.DataOutValid);
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (b1.DataOut !== 8'h55 || b0.DataOut !== 8'h11) begin
            errors++;
            $display("FAIL overwrite_readback got u1=%h u0=%h exp u1=55 u0=11",
                     b1.DataOut, b0.DataOut);
        end
    endtask

    task automatic test_both();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'h99);
        checks++;
        if ({b0.Err, b0.Addr, b0.DataOutValid, b0.Full} !== 5'b11000) begin
            errors++;
            $display("FAIL we_re err/addr/v/full got %b exp 11000",
                     {b0.Err, b0.Addr, b0.DataOutValid, b0.Full});
        end
        checks++;
        if (b0.DataOut !== 8'h22) begin
            errors++;
            $display("FAIL we_re_dataout got %h exp 22", b0.DataOut);
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (b0.DataOut !== 8'h33 || b0.Addr !== 2'd3 || b0.Err !== 1'b0) begin
            errors++;
            $display("FAIL we_re_readback got do=%h a=%0d e=%b exp do=33 a=3 e=0",
                     b0.DataOut, b0.Addr, b0.Err);
        end
    endtask

    task automatic test_clr_we();
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, altD[i]);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if ({b0.Addr, b0.Full, b0.DataOut} !== {2'd3, 1'b1, 8'hA3}) begin
            errors++;
            $display("FAIL clr_we_setup got a=%0d f=%b do=%h exp a=3 f=1 do=a3",
                     b0.Addr, b0.Full, b0.DataOut);
        end
        drive(1'b1, 1'b0, 1'b1, 8'hEE);
        checks++;
        if ({b0.Addr, b0.Full, b0.Wrap, b0.Err, b0.DataOutValid} !== 6'h0) begin
            errors++;
            $display("FAIL clr_we got a=%0d f=%b w=%b e=%b v=%b exp all 0",
                     b0.Addr, b0.Full, b0.Wrap, b0.Err, b0.DataOutValid);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (b0.DataOut !== 8'hA4 || b1.DataOut !== 8'hA4) begin
            errors++;
            $display("FAIL clr_we_mem3 got u0=%h u1=%h exp a4",
                     b0.DataOut, b1.DataOut);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h61);
        drive(1'b1, 1'b0, 1'b0, 8'h62);
        checks++;
        if (b0.Addr !== 2'd2) begin
            errors++;
            $display("FAIL rst_setup addr got %0d exp 2", b0.Addr);
        end
        @(negedge clock);
        setIn(1'b1, 1'b0, 1'b0, 8'h63);
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({b0.Addr, b0.Full, b0.DataOut} !== 11'h0) begin
            errors++;
            $display("FAIL async_rst got a=%0d f=%b do=%h exp 0 0 00",
                     b0.Addr, b0.Full, b0.DataOut);
        end
        @(posedge clock);
        #1;
        checks++;
        if (b0.Addr !== 2'd0 || b0.Wrap !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold got a=%0d w=%b exp 0 0", b0.Addr, b0.Wrap);
        end
        @(negedge clock);
        Reset = 1'b0;
        setIn(1'b0, 1'b1, 1'b0, 8'h00);
        @(posedge clock);
        #1;
        setIn(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({b0.DataOut, b0.DataOutValid, b0.Addr} !== {8'h61, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL rst_resume got do=%h v=%b a=%0d exp 61 1 1",
                     b0.DataOut, b0.DataOutValid, b0.Addr);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h65);
        checks++;
        if (b0.Addr !== 2'd2 || b0.Err !== 1'b0) begin
            errors++;
            $display("FAIL rst_resume_wr got a=%0d e=%b exp 2 0", b0.Addr, b0.Err);
        end
    endtask

    initial begin
        setIn(1'b0, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_fill();
        test_read();
        test_reject();
        test_both();
        test_clr_we();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_xfer_param.md
Name: mc_xfer_param

Overview:
Parametrised successor to the fixed 4x8 transfer-module memory controller. It holds a DEPTH x DATA_W register-file memory behind an auto-advancing address counter and supports write-and-advance, read-and-advance and address clear. It also reports fill status, wrap-around and illegal-command errors. It sits on either side of the memory transfer path, as source buffer or destination buffer, driven by the transfer FSM.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 4, number of memory words (power of two, >=2)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
WRAP_EN, 0, 1 = writes when Full overwrite from address 0; 0 = writes when Full are rejected

Ports:
clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
WE  in  1  write request: store DataIn at Addr, then advance Addr
RE  in  1  read request: fetch Mem[Addr] to DataOut, then advance Addr
Clr  in  1  synchronous address/flag clear
DataIn  in  DATA_W  write data
Addr  out  ADDR_W  current address pointer (registered)
DataOut  out  DATA_W  registered read data
DataOutValid  out  1  one-cycle pulse; DataOut holds a new read word
Full  out  1  sticky; last location (DEPTH-1) has been written since last Clr/Reset
Wrap  out  1  one-cycle pulse; Addr advanced from DEPTH-1 to 0
Err  out  1  one-cycle pulse; illegal or rejected command

Behaviour:
- Reset (async, active-high) sets Addr=0, DataOut=0, DataOutValid=0, Full=0, Wrap=0, Err=0. Memory contents are not reset.
- Reset asserted mid-operation aborts any command in that cycle; no memory write occurs while Reset=1.
- Commands are sampled on the rising edge. Priority: Clr > (WE&RE) > WE > RE > idle.
- Clr: Addr<=0, Full<=0. No memory write, no read. DataOutValid=0, Wrap=0, Err=0. WE/RE are ignored in the same cycle.
- WE&RE together: Err pulses for 1 cycle. Addr, Mem, Full and DataOut are unchanged.
- WE alone, Full=0 or WRAP_EN=1: Mem[Addr]<=DataIn; Addr<=Addr+1 mod DEPTH.
  - If Addr==DEPTH-1: Full<=1 and Wrap pulses.
- WE alone, Full=1 and WRAP_EN=0: write is dropped, Addr holds, Err pulses.
- RE alone: DataOut<=Mem[Addr]; DataOutValid pulses the next cycle, so read latency is 1 clock from the command edge; Addr<=Addr+1 mod DEPTH.
  - If Addr==DEPTH-1, Wrap pulses. Reads are always permitted and never change Full.
- Idle (no command): all registers hold; pulses deassert.
- DataOut holds its last read value until the next read; only DataOutValid marks new data.
- Address arithmetic is unsigned ADDR_W bits with natural modulo-DEPTH wrap. No out-of-range address is reachable.
- Read of a never-written location returns undefined data. Benches must not check it.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Package mc_pkg holds:
  - the command enum: CMD_IDLE, CMD_CLR, CMD_WR, CMD_WR_REJ, CMD_RD, CMD_ERR
  - a decode function (Clr, WE, RE, Full, WRAP_EN) -> command, shared with the transfer FSM.
- One sub-module, mc_addr_ctr: ADDR_W counter with clear, advance enable and terminal-count output (Addr==DEPTH-1). It drives Addr and Wrap.
- Memory array, data path and flags stay in the top module.

Test Plan:
- Reset then 4 writes (DEPTH=4, DATA_W=8) of 0x11,0x22,0x33,0x44 -> Addr 0->1->2->3->0; Wrap pulses on the 4th write; Full=1 after it; Err=0 throughout.
- After the fill above, 4 reads -> DataOutValid pulses 1 cycle after each read; DataOut=0x11,0x22,0x33,0x44; Wrap on the 4th read; Full stays 1.
- WRAP_EN=0, Full=1, write 0x55 -> Err pulse, Addr unchanged at 0, next read returns 0x11. WRAP_EN=1 same stimulus -> Mem[0]=0x55, Addr=1, Err=0.
- WE=RE=1 at Addr=2 -> Err pulse, Addr stays 2, DataOutValid=0, memory unchanged on read-back.
- Clr together with WE at Addr=3, Full=1 -> Addr=0, Full=0, no write (Mem[3] read-back unchanged), no pulses.
- Reset asserted asynchronously between edges during a write burst at Addr=2 -> Addr, Full and DataOut go to 0 immediately. No write while Reset=1. Normal operation resumes on the first edge after deassertion.
